// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N_IN:1 valid/ready stream multiplexer with round-robin
// arbitration and a single registered output stage (1-cycle latency, full
// throughput).
// Optional feature macro: RR_MUX_PKT_LOCK_EN -- adds In_last/Out_last and
// holds the grant on one channel until that channel finishes its packet.
module rr_stream_mux #(
  parameter  int WIDTH = 8,
  parameter  int N_IN  = 4,
  localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [N_IN*WIDTH-1:0] In_data,
  input  logic [N_IN-1:0]       In_valid,
  output logic [N_IN-1:0]       In_ready,
  output logic [WIDTH-1:0]      Out_data,
  output logic [SEL_W-1:0]      Out_sel,
  output logic                  Out_valid,
  input  logic                  Out_ready
`ifdef RR_MUX_PKT_LOCK_EN
  ,
  input  logic [N_IN-1:0]       In_last,
  output logic                  Out_last
`endif
);

  logic [SEL_W-1:0] ptr;
  logic             load;
  logic [N_IN-1:0]  grant;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             found;
  logic [SEL_W-1:0] next_ptr;
`ifdef RR_MUX_PKT_LOCK_EN
  logic             lock;
  logic [SEL_W-1:0] lock_ch;
  logic             grant_last;
`endif

  // Round-robin search starting at ptr; wraps at N_IN so non-power-of-two
  // channel counts never probe a nonexistent channel.
  always_comb begin
    int idx;
    grant      = '0;
    grant_idx  = '0;
    grant_data = '0;
    found      = 1'b0;
`ifdef RR_MUX_PKT_LOCK_EN
    grant_last = 1'b0;
`endif
    for (int k = 0; k < N_IN; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_IN) idx = idx - N_IN;
`ifdef RR_MUX_PKT_LOCK_EN
      if (!found && In_valid[idx] && (!lock || (idx == int'(lock_ch)))) begin
        grant_last = In_last[idx];
`else
      if (!found && In_valid[idx]) begin
`endif
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
        grant_data = In_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  assign load     = ~Out_valid | Out_ready;
  // Reset is folded in so no channel sees ready while the block is held in reset.
  assign In_ready = (load & Rst_n) ? grant : '0;
  assign next_ptr = (int'(grant_idx) == N_IN - 1) ? '0 : grant_idx + SEL_W'(1);

  // Output register, pointer and packet lock update on each accepted beat.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Out_valid <= 1'b0;
      Out_data  <= '0;
      Out_sel   <= '0;
      ptr       <= '0;
`ifdef RR_MUX_PKT_LOCK_EN
      Out_last  <= 1'b0;
      lock      <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (load) begin
      if (found) begin
        Out_valid <= 1'b1;
        Out_data  <= grant_data;
        Out_sel   <= grant_idx;
`ifdef RR_MUX_PKT_LOCK_EN
        Out_last  <= grant_last;
        if (grant_last) begin
          lock <= 1'b0;
          ptr  <= next_ptr;
        end else begin
          lock    <= 1'b1;
          lock_ch <= grant_idx;
        end
`else
        ptr       <= next_ptr;
`endif
      end else begin
        Out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: a 4-channel and a 3-channel instance run side by
// side, each compared every cycle against a behavioural round-robin model,
// plus directed scenarios with fixed expected sequences.
module tb_rr_stream_mux;

`ifdef RR_MUX_PKT_LOCK_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] vld  [2];
  logic [7:0] dat  [2][4];
  logic [3:0] lst  [2];
  logic       ordy [2];

  logic [31:0] in_data4;
  logic [23:0] in_data3;
  assign in_data4 = {dat[0][3], dat[0][2], dat[0][1], dat[0][0]};
  assign in_data3 = {dat[1][2], dat[1][1], dat[1][0]};

  logic [3:0] rdy4;
  logic [7:0] od4;
  logic [1:0] os4;
  logic       ov4;
  logic [2:0] rdy3;
  logic [7:0] od3;
  logic [1:0] os3;
  logic       ov3;
`ifdef RR_MUX_PKT_LOCK_EN
  logic       ol4;
  logic       ol3;
`endif

  rr_stream_mux #(.WIDTH(8), .N_IN(4)) dut4 (
    .Clk(clk), .Rst_n(rst_n),
    .In_data(in_data4), .In_valid(vld[0]), .In_ready(rdy4),
    .Out_data(od4), .Out_sel(os4), .Out_valid(ov4), .Out_ready(ordy[0])
`ifdef RR_MUX_PKT_LOCK_EN
    , .In_last(lst[0]), .Out_last(ol4)
`endif
  );

  rr_stream_mux #(.WIDTH(8), .N_IN(3)) dut3 (
    .Clk(clk), .Rst_n(rst_n),
    .In_data(in_data3), .In_valid(vld[1][2:0]), .In_ready(rdy3),
    .Out_data(od3), .Out_sel(os3), .Out_valid(ov3), .Out_ready(ordy[1])
`ifdef RR_MUX_PKT_LOCK_EN
    , .In_last(lst[1][2:0]), .Out_last(ol3)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model state, one slot per instance.
  int         nn    [2] = '{4, 3};
  int         m_ptr [2];
  int         m_lock[2];
  int         m_lch [2];
  logic       m_v   [2];
  logic [7:0] m_d   [2];
  int         m_s   [2];
  logic       m_l   [2];

  function automatic int gsel(int u);
    int c;
    if (PKT && m_lock[u] != 0) return vld[u][m_lch[u]] ? m_lch[u] : -1;
    for (int k = 0; k < nn[u]; k++) begin
      c = (m_ptr[u] + k) % nn[u];
      if (vld[u][c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_rdy(int u);
    int g;
    g = gsel(u);
    if (!rst_n || (m_v[u] && !ordy[u]) || g < 0) return 4'b0;
    return 4'(1 << g);
  endfunction

  task automatic model_edge();
    for (int u = 0; u < 2; u++) begin
      int g;
      g = gsel(u);
      if (!rst_n) begin
        m_ptr[u] = 0; m_lock[u] = 0; m_lch[u] = 0;
        m_v[u] = 1'b0; m_d[u] = 8'h00; m_s[u] = 0; m_l[u] = 1'b0;
      end else if (!m_v[u] || ordy[u]) begin
        if (g < 0) begin
          m_v[u] = 1'b0;
        end else begin
          m_v[u] = 1'b1;
          m_d[u] = dat[u][g];
          m_s[u] = g;
          if (PKT) begin
            m_l[u] = lst[u][g];
            if (lst[u][g]) begin
              m_lock[u] = 0;
              m_ptr[u]  = (g + 1) % nn[u];
            end else begin
              m_lock[u] = 1;
              m_lch[u]  = g;
            end
          end else begin
            m_ptr[u] = (g + 1) % nn[u];
          end
        end
      end
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic cycle();
    #1;
    chk("rdy4", 32'(rdy4), 32'(exp_rdy(0)));
    chk("rdy3", 32'(rdy3), 32'(exp_rdy(1)));
    @(posedge clk);
    model_edge();
    #1;
    chk("valid4", 32'(ov4), 32'(m_v[0]));
    chk("data4",  32'(od4), 32'(m_d[0]));
    chk("sel4",   32'(os4), 32'(m_s[0]));
    chk("valid3", 32'(ov3), 32'(m_v[1]));
    chk("data3",  32'(od3), 32'(m_d[1]));
    chk("sel3",   32'(os3), 32'(m_s[1]));
`ifdef RR_MUX_PKT_LOCK_EN
    chk("last4", 32'(ol4), 32'(m_l[0]));
    chk("last3", 32'(ol3), 32'(m_l[1]));
`endif
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      vld[u] = 4'h0; lst[u] = 4'hF; ordy[u] = 1'b1;
      for (int c = 0; c < 4; c++) dat[u][c] = 8'(8'hA0 + c);
    end
    vld[0] = 4'hF;
    @(negedge clk);

    // Held in reset with requests pending: no ready, outputs cleared.
    cycle();
    cycle();
    chk("reset_valid", 32'(ov4), 32'd0);

    // All channels valid: strict rotation 0,1,2,3,0,1.
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      cycle();
      chk("rr_sel",  32'(os4), 32'(j % 4));
      chk("rr_data", 32'(od4), 32'(8'hA0 + (j % 4)));
    end

    // Backpressure for 3 cycles, then release.
    ordy[0] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cycle();
      chk("bp_rdy",  32'(rdy4), 32'd0);
      chk("bp_sel",  32'(os4), 32'd1);
      chk("bp_data", 32'(od4), 32'hA1);
    end
    ordy[0] = 1'b1;
    cycle();
    chk("bp_resume_sel",  32'(os4), 32'd2);
    chk("bp_resume_data", 32'(od4), 32'hA2);

    // Sparse single beat on channel 1.
    vld[0] = 4'b0010;
    dat[0][1] = 8'h5C;
    cycle();
    chk("sparse_valid", 32'(ov4), 32'd1);
    chk("sparse_sel",   32'(os4), 32'd1);
    chk("sparse_data",  32'(od4), 32'h5C);
    vld[0] = 4'b0000;
    cycle();
    chk("sparse_drain", 32'(ov4), 32'd0);

    // 3-channel wrap: move ptr to 2, then only ch0/ch2 valid.
    vld[1] = 4'b0010;
    cycle();
    vld[1] = 4'b0101;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("wrap_no_ch1", 32'(rdy3[1]), 32'd0);
      cycle();
      chk("wrap_sel", 32'(os3), (j % 2 == 0) ? 32'd2 : 32'd0);
    end
    vld[1] = 4'b0000;
    cycle();

    // Randomised traffic on both instances.
    for (int j = 0; j < 400; j++) begin
      for (int u = 0; u < 2; u++) begin
        vld[u]  = 4'($urandom_range(0, 15));
        ordy[u] = ($urandom_range(0, 3) != 0);
        lst[u]  = PKT ? 4'($urandom_range(0, 15)) : 4'hF;
        for (int c = 0; c < 4; c++) dat[u][c] = 8'($urandom_range(0, 255));
      end
      cycle();
    end

    // Reset in the middle of a stream.
    for (int u = 0; u < 2; u++) begin
      vld[u] = 4'hF; ordy[u] = 1'b1; lst[u] = 4'hF;
    end
    cycle();
    chk("pre_rst_valid", 32'(ov4), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(ov4), 32'd0);
    chk("rst_async_rdy",   32'(rdy4), 32'd0);
    cycle();
    rst_n = 1'b1;
    #1;
    chk("first_grant", 32'(rdy4), 32'b0001);
    cycle();
    chk("first_sel", 32'(os4), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
